// File: rtl/fetch_sequencer_pkg.sv
// Shared state encodings, constants and bundle types for the fetch sequencer.
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    FS_BOOT  = 2'd0,
    FS_FETCH = 2'd1,
    FS_HOLD  = 2'd2
  } fs_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

  typedef struct packed {
    logic        vld;
    logic        annul;
    logic [31:0] target;
  } pend_t;

  typedef struct packed {
    logic        vld;
    logic [31:0] instr;
    logic [31:0] pc8;
  } fd_t;

  function automatic logic [31:0] pc_align(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_sequencer_fd_skid_buf.sv
// Holds one fetched instruction while decode stalls; loads in one cycle, drains on clear.
// No internal backpressure: the owner guarantees load and clear are never asserted together.
module fd_skid_buf
  import fetch_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] din,
  output logic        valid,
  output logic [31:0] dout
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      dout  <= NOP_INSTR;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage PC, F/D register and redirect sequencing; one edge from imem_addr to F/D, 1 instr/cycle.
// Decode stall holds F/D; a fetch completing under stall is parked in the skid buffer (imem_req drops).
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        d_stall,
  input  logic        d_redirect,
  input  logic [31:0] d_target,
  input  logic        d_annul,
  output logic        fd_valid,
  output logic [31:0] fd_instr,
  output logic [31:0] fd_pc8
);

  fs_state_t   state, state_nxt;
  logic [31:0] pc_f, next_pc, tgt, hold_buf, ho_instr;
  logic        hold_load, hold_vld, handover, acc, ann, annul_eff;
  pend_t       pend;
  fd_t         fd;

  assign tgt       = pc_align(d_target);
  assign acc       = d_redirect & fd.vld & ~d_stall;
  assign ann       = d_annul & fd.vld & ~d_stall;
  assign handover  = ((state == FS_FETCH && imem_ready) || state == FS_HOLD) && !d_stall;
  assign ho_instr  = hold_vld ? hold_buf : imem_rdata;
  assign annul_eff = pend.vld ? pend.annul : ann;
  assign next_pc   = pend.vld ? pend.target : (acc ? tgt : pc_f + 32'd4);

  assign imem_addr = pc_align(pc_f);
  assign fd_valid  = fd.vld;
  assign fd_instr  = fd.instr;
  assign fd_pc8    = fd.pc8;

  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    hold_load = 1'b0;
    case (state)
      FS_BOOT:  state_nxt = FS_FETCH;
      FS_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready && d_stall) begin
          hold_load = 1'b1;
          state_nxt = FS_HOLD;
        end
      end
      FS_HOLD:  if (!d_stall) state_nxt = FS_FETCH;
      default:  state_nxt = FS_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FS_BOOT;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_f <= pc_align(RESET_PC);
      fd   <= '0;
      pend <= '0;
    end else begin
      if (handover) pc_f <= next_pc;

      if (!d_stall) begin
        if (handover) begin
          fd.vld   <= !annul_eff;
          fd.instr <= ho_instr;
          fd.pc8   <= pc_f + 32'd8;
        end else begin
          fd.vld   <= 1'b0;
        end
      end

      // An annul-only pend resumes sequentially after the delay slot (pc_f is the slot here).
      if (handover) begin
        pend.vld <= 1'b0;
      end else if (acc || ann) begin
        pend.vld    <= 1'b1;
        pend.annul  <= ann;
        pend.target <= acc ? tgt : pc_f + 32'd4;
      end
    end
  end

  fd_skid_buf u_hold (
    .clk   (clk),
    .rst_n (reset),
    .load  (hold_load),
    .clear (handover),
    .din   (imem_rdata),
    .valid (hold_vld),
    .dout  (hold_buf)
  );

endmodule
